decoder_2to4_seq: RTL and testbench

Sequenced 2-to-4 decoder: accepts 2-bit codes over a valid/ready handshake, buffers them in a small FIFO, and presents each code's 4-bit pattern for a programmable dwell time. It is the decode counterpart of the team's 4-to-2 encoder and uses the same code/pattern mapping, so encoder output round-trips through this block. It sits between a code source (UART command parser, test sequencer) and pattern-driven outputs such as LEDs or select lines.

---
 rtl/decoder_pkg.sv | 26 ++
 rtl/decoder_2to4_seq_fifo.sv | 44 ++++
 rtl/decoder_2to4_seq.sv | 108 ++++++++++
 tb/tb_decoder_2to4_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and the fixed code->pattern map for the 2-to-4 sequenced decoder.
// The mapping matches the 4-to-2 encoder so encoder output round-trips.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [3:0] PAT_00 = 4'b1101;
  localparam logic [3:0] PAT_01 = 4'b1110;
  localparam logic [3:0] PAT_10 = 4'b0110;
  localparam logic [3:0] PAT_11 = 4'b0001;

  function automatic logic [3:0] code2pattern(input logic [1:0] code);
    logic [3:0] pat;
    case (code)
      2'b00:   pat = PAT_00;
      2'b01:   pat = PAT_01;
      2'b10:   pat = PAT_10;
      default: pat = PAT_11;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/decoder_2to4_seq_fifo.sv
// code_fifo: DEPTH x WIDTH synchronous FIFO, wrap-bit pointers, same-edge push+pop.
// Zero-latency read of the head entry; push ignored when full, pop ignored when empty.
// Backpressure: caller gates push with !full.
module code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + PTR_ONE;
      if (pop  && !empty) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rptr[AW-1:0]];
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/decoder_2to4_seq.sv
// decoder_2to4_seq: queued 2->4 decode, each pattern held DWELL cycles; DECODER_HOLD_LAST_EN keeps last pattern when idle.
// Latency: code accepted at edge N drives out_pattern/out_valid after edge N+1.
// Backpressure: in_ready = !full (low during rst); codes beyond DEPTH stall upstream.
module decoder_2to4_seq #(
  parameter int DWELL = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_code,
  output logic       in_ready,
  output logic [3:0] out_pattern,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  import decoder_pkg::*;

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] dwell_cnt;
  logic [3:0]    pattern_q;
  logic          done_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          finish;
  logic [1:0]    head_code;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;

  code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (in_code),
    .pop      (pop),
    .pop_dat  (head_code),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Last hold cycle: chain straight into the next entry, or drain.
        if (dwell_cnt == '0) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      pattern_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish;
      if (pop) begin
        pattern_q <= code2pattern(head_code);
        dwell_cnt <= DWELL_LOAD;
      end else if ((state == HOLD) && (dwell_cnt != '0)) begin
        dwell_cnt <= dwell_cnt - CNT_ONE;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = out_valid || !fifo_empty;
  assign done      = done_q;

`ifdef DECODER_HOLD_LAST_EN
  assign out_pattern = pattern_q;
`else
  assign out_pattern = (state == HOLD) ? pattern_q : 4'b0000;
`endif

endmodule

// File: tb/tb_decoder_2to4_seq.sv
// Bench for decoder_2to4_seq: DWELL=4 and DWELL=1 instances, scoreboard of expected held patterns.
module tb_decoder_2to4_seq;

  localparam int DW  = 4;
  localparam int DW1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'b00;
  logic       in_valid1 = 1'b0;
  logic [1:0] in_code1 = 2'b00;

  logic       in_ready, out_valid, busy, done;
  logic [3:0] out_pattern;
  logic       in_ready1, out_valid1, busy1, done1;
  logic [3:0] out_pattern1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] q  [$];
  logic [3:0] q1 [$];
  logic [3:0] last_pat = 4'h0;
  logic [3:0] last_pat1 = 4'h0;
  int done_cnt = 0;
  int run_len = 0;
  int last_run = 0;

  always #5 clk = ~clk;

  decoder_2to4_seq #(.DWELL(DW), .DEPTH(4)) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_code (in_code),
    .in_ready (in_ready), .out_pattern (out_pattern), .out_valid (out_valid),
    .busy (busy), .done (done)
  );

  decoder_2to4_seq #(.DWELL(DW1), .DEPTH(4)) dut1 (
    .clk (clk), .rst (rst), .in_valid (in_valid1), .in_code (in_code1),
    .in_ready (in_ready1), .out_pattern (out_pattern1), .out_valid (out_valid1),
    .busy (busy1), .done (done1)
  );

  function automatic logic [3:0] ref_pat(input logic [1:0] c);
    case (c)
      2'b00:   return 4'b1101;
      2'b01:   return 4'b1110;
      2'b10:   return 4'b0110;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] idle_exp(input logic [3:0] last);
`ifdef DECODER_HOLD_LAST_EN
    return last;
`else
    return 4'h0 & last;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the DWELL=4 instance: one queue entry per expected hold cycle.
  always @(negedge clk) begin
    logic [3:0] e;
    if (out_valid) begin
      e = (q.size() > 0) ? q.pop_front() : 4'hx;
      check("pattern", 32'(out_pattern), 32'(e));
      last_pat = e;
      run_len++;
    end else begin
      check("idle_pattern", 32'(out_pattern), 32'(idle_exp(last_pat)));
      if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
    if (done) done_cnt++;
    if (rst) begin
      q.delete();
      last_pat = 4'h0;
      run_len  = 0;
    end else if (in_valid && in_ready) begin
      for (int k = 0; k < DW; k++) q.push_back(ref_pat(in_code));
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (out_valid1) begin
      e = (q1.size() > 0) ? q1.pop_front() : 4'hx;
      check("pattern_dw1", 32'(out_pattern1), 32'(e));
      last_pat1 = e;
    end else begin
      check("idle_pattern_dw1", 32'(out_pattern1), 32'(idle_exp(last_pat1)));
    end
    if (rst) begin
      q1.delete();
      last_pat1 = 4'h0;
    end else if (in_valid1 && in_ready1) begin
      for (int k = 0; k < DW1; k++) q1.push_back(ref_pat(in_code1));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_drain"}, 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int idx;
    int guard;
    logic saw_full;
    logic acc;

    // Reset state
    repeat (2) nxt();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_pattern", 32'(out_pattern), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Single code 10: one-cycle latency, DWELL hold, done right after
    nxt();
    in_valid = 1'b1;
    in_code  = 2'b10;
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_latency_valid", 32'(out_valid), 32'(0));
    check("single_busy", 32'(busy), 32'(1));
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      check("single_hold_valid", 32'(out_valid), 32'(1));
      check("single_hold_pat", 32'(out_pattern), 32'(4'b0110));
      check("single_hold_done", 32'(done), 32'(0));
    end
    @(negedge clk);
    check("single_done", 32'(done), 32'(1));
    check("single_valid_fall", 32'(out_valid), 32'(0));
    @(negedge clk);
    check("single_done_once", 32'(done), 32'(0));
    check("single_busy_end", 32'(busy), 32'(0));

    // Burst 00,01,10,11 on consecutive edges
    nxt();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = 2'(i);
      nxt();
    end
    in_valid = 1'b0;
    wait_idle("burst");
    check("burst_run_len", 32'(last_run), 32'(16));
    check("burst_done_count", 32'(done_cnt - d0), 32'(1));

    // in_valid held with 8 codes: stalls while full, nothing lost
    nxt();
    saw_full = 1'b0;
    idx = 0;
    guard = 0;
    in_valid = 1'b1;
    in_code  = 2'b00;
    while (idx < 8 && guard < 200) begin
      @(negedge clk);
      if (!in_ready) saw_full = 1'b1;
      acc = in_ready;
      nxt();
      guard++;
      if (acc) begin
        idx++;
        in_code = (idx < 4) ? 2'(idx) : 2'(7 - idx);
      end
    end
    in_valid = 1'b0;
    check("fill_all_accepted", 32'(idx), 32'(8));
    check("fill_saw_full", 32'(saw_full), 32'(1));
    wait_idle("fill");
    check("fill_run_len", 32'(last_run), 32'(32));
    check("fill_q_empty", 32'(q.size()), 32'(0));

    // Reset during the 2nd hold cycle with 3 codes in flight
    nxt();
    d0 = done_cnt;
    in_valid = 1'b1;
    in_code  = 2'b00;
    nxt();
    in_code  = 2'b01;
    nxt();
    in_code  = 2'b10;
    nxt();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'(0));
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'(0));
    check("midrst_pattern", 32'(out_pattern), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'(0));
    nxt();
    in_valid = 1'b1;
    in_code  = 2'b11;
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    check("after_rst_latency", 32'(out_valid), 32'(0));
    @(negedge clk);
    check("after_rst_valid", 32'(out_valid), 32'(1));
    check("after_rst_pat", 32'(out_pattern), 32'(4'b0001));
    wait_idle("after_rst");

    // Code accepted in the final hold cycle: one-cycle gap plus done
    nxt();
    in_valid = 1'b1;
    in_code  = 2'b01;
    nxt();
    in_valid = 1'b0;
    repeat (DW) nxt();
    in_valid = 1'b1;
    in_code  = 2'b10;
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    check("gap_valid", 32'(out_valid), 32'(0));
    check("gap_done", 32'(done), 32'(1));
    @(negedge clk);
    check("gap_resume_valid", 32'(out_valid), 32'(1));
    check("gap_resume_pat", 32'(out_pattern), 32'(4'b0110));
    wait_idle("gap");

    // DWELL=1: 11,00,01 back to back
    nxt();
    in_valid1 = 1'b1;
    in_code1  = 2'b11;
    nxt();
    in_code1  = 2'b00;
    @(negedge clk);
    check("dw1_latency", 32'(out_valid1), 32'(0));
    nxt();
    in_code1  = 2'b01;
    @(negedge clk);
    check("dw1_pat0", 32'(out_pattern1), 32'(4'b0001));
    nxt();
    in_valid1 = 1'b0;
    @(negedge clk);
    check("dw1_pat1", 32'(out_pattern1), 32'(4'b1101));
    check("dw1_valid1", 32'(out_valid1), 32'(1));
    nxt();
    @(negedge clk);
    check("dw1_pat2", 32'(out_pattern1), 32'(4'b1110));
    nxt();
    @(negedge clk);
    check("dw1_done", 32'(done1), 32'(1));
    check("dw1_valid_fall", 32'(out_valid1), 32'(0));
    nxt();
    @(negedge clk);
    check("dw1_done_once", 32'(done1), 32'(0));
    check("dw1_busy_end", 32'(busy1), 32'(0));

    check("q_drained", 32'(q.size()), 32'(0));
    check("q1_drained", 32'(q1.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
